spi_txn_arbiter: RTL and testbench

SPI_TXN_ARBITER -- requirements
Module: spi_txn_arbiter

---
 rtl/spi_arb_pkg.sv | 21 ++
 rtl/spi_rr_pick.sv | 27 ++
 rtl/spi_txn_arbiter.sv | 98 +++++++++
 tb/tb_spi_txn_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared definitions for the spi transaction arbiter: FSM encoding,
// default sizing and a small width helper used by the top and the picker.
package spi_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 12;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  // index width for n requesters, never below 1 bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo
// NUM_REQ. Purely combinational.
module spi_rr_pick
  import spi_arb_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  localparam int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      winner,
  output logic               valid
);

  // scan from the farthest offset back to ptr so the closest hit wins last
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % NUM_REQ]) begin
        winner = IW'((int'(ptr) + i) % NUM_REQ);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one spi master among NUM_REQ requesters. A request is granted in
// IDLE, its word is latched and launched, and the arbiter waits for the
// master's done (or a timeout) before acking and releasing the bus.
module spi_txn_arbiter
  import spi_arb_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  parameter  int DATA_W  = DATA_W_DEF,
  parameter  int TIMEOUT = TIMEOUT_DEF,
  localparam int IW      = idx_w(NUM_REQ),
  localparam int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        err,
  output logic                      busy,
  output logic [IW-1:0]             grant_id,
  output logic                      spi_start,
  output logic [DATA_W-1:0]         spi_din,
  input  logic                      spi_done,
  input  logic                      spi_cs
);

  arb_state_t    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_nxt;
  logic [IW-1:0] pick_id;
  logic          pick_vld;
  logic [CW-1:0] cnt;

  spi_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_id),
    .valid  (pick_vld)
  );

  // pointer moves just past whoever completed, wrapping to 0
  assign ptr_nxt = (grant_id == IW'(NUM_REQ-1)) ? '0 : grant_id + IW'(1);

  // arbitration FSM; every output is a register written here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      spi_start <= 1'b0;
      spi_din   <= '0;
      ack       <= '0;
      err       <= '0;
      busy      <= 1'b0;
      grant_id  <= '0;
      ptr       <= '0;
      cnt       <= '0;
    end else begin
      // ack/err are single-cycle pulses
      ack <= '0;
      err <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            grant_id  <= pick_id;
            spi_din   <= req_data[pick_id*DATA_W +: DATA_W];
            spi_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // done has priority over a coincident timeout
          if (spi_done || cnt == CW'(TIMEOUT-1)) begin
            ack[grant_id] <= 1'b1;
            err[grant_id] <= !spi_done;
            spi_start     <= 1'b0;
            ptr           <= ptr_nxt;
            state         <= ST_RELEASE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_RELEASE: begin
          // hold off until the master is idle so a level done acks once
          if (!spi_done && spi_cs) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Bench for spi_txn_arbiter: table of single transactions, directed
// multi-cycle sequences and a randomized run against a transaction model.
module tb_spi_txn_arbiter;
  import spi_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 12;
  localparam int TO = 40;
  localparam int IW = 2;
  localparam logic [N*DW-1:0] TBL_DATA = {12'hD3C, 12'h7E1, 12'hA5A, 12'h0F0};

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    ack, err;
  logic            busy;
  logic [IW-1:0]   grant_id;
  logic            spi_start;
  logic [DW-1:0]   spi_din;
  logic            spi_done = 1'b0;
  logic            spi_cs = 1'b1;

  spi_txn_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .ack(ack), .err(err), .busy(busy), .grant_id(grant_id),
    .spi_start(spi_start), .spi_din(spi_din),
    .spi_done(spi_done), .spi_cs(spi_cs)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // spi master model
  int sp_delay = 5, sp_len = 1, sp_cnt = 0, sp_hold = 0;
  bit sp_never = 0, sp_rand = 0, sp_active = 0, sp_fired = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        spi_done = 0; spi_cs = 1; sp_active = 0;
        continue;
      end
      if (spi_done) begin
        sp_hold--;
        if (sp_hold <= 0) spi_done = 0;
      end
      if (sp_active && !spi_start && !spi_done) begin
        sp_active = 0; spi_cs = 1;
      end else if (sp_active && !spi_done && !sp_fired) begin
        sp_cnt++;
        if (!sp_never && sp_cnt >= sp_delay) begin
          spi_done = 1; sp_hold = sp_len; sp_fired = 1;
        end
      end
      if (!sp_active && spi_start) begin
        sp_active = 1; spi_cs = 0; sp_cnt = 0; sp_fired = 0;
        if (sp_rand) begin
          sp_never = ($urandom_range(5) == 0);
          sp_delay = $urandom_range(30, 1);
          sp_len   = $urandom_range(4, 1);
        end
      end
    end
  end

  // reference pick: lowest set index >= p, otherwise lowest set index
  function automatic int ref_pick(input logic [N-1:0] r, input int p);
    for (int k = p; k < N; k++) if (r[k]) return k;
    for (int k = 0; k < p; k++) if (r[k]) return k;
    return -1;
  endfunction

  // monitor and random-phase scoreboard
  int ack_cnt = 0, start_cnt = 0, inv_bad = 0, rnd_txn = 0;
  int grant_log[$];
  bit prev_start = 0;
  bit rnd_on = 0, m_act = 0, din_moved = 0;
  int m_ptr = 0, m_g = -1;
  logic [DW-1:0] m_din = '0;

  initial begin
    forever begin
      @(posedge clk); #1;
      if ($countones(ack) > 1 || $countones(err) > 1 || (err & ~ack) != '0) inv_bad++;
      if (|ack) ack_cnt++;
      if (spi_start && !prev_start) begin
        start_cnt++;
        grant_log.push_back(int'(grant_id));
        if (rnd_on) begin
          m_g = ref_pick(req, m_ptr);
          chk("rnd_grant", grant_id, m_g);
          if (m_g >= 0) m_din = req_data[m_g*DW +: DW];
          chk("rnd_din", spi_din, m_din);
          m_act = 1; din_moved = 0;
        end
      end
      if (rnd_on && m_act) begin
        if (spi_din !== m_din) din_moved = 1;
        if (|ack) begin
          chk("rnd_ack", ack, 1 << m_g);
          chk("rnd_err", err, sp_never ? (1 << m_g) : 0);
          chk("rnd_din_stable", din_moved, 0);
          m_ptr = (m_g + 1) % N;
          m_act = 0;
          rnd_txn++;
        end
      end
      prev_start = spi_start;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic wait_start(input int lim, output bit ok, output int n);
    ok = 0; n = 0;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk); #1; n++;
      if (spi_start) begin ok = 1; break; end
    end
  endtask

  task automatic wait_ack(input int lim, output bit ok, output int n);
    ok = 0; n = 0;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk); #1; n++;
      if (|ack) begin ok = 1; break; end
    end
  endtask

  typedef struct {
    logic [N-1:0]  r;
    int            dly;
    int            len;
    bit            nev;
    int            g;
    logic [DW-1:0] din;
    bit            e;
  } vec_t;

  vec_t tbl[7];

  task automatic run_vec(input int idx, input vec_t v);
    bit ok; int n, a0, s0;
    do_reset();
    sp_delay = v.dly; sp_len = v.len; sp_never = v.nev;
    req_data = TBL_DATA;
    a0 = ack_cnt; s0 = start_cnt;
    @(negedge clk); req = v.r;
    wait_start(10, ok, n);
    chk($sformatf("vec%0d_start", idx), ok, 1);
    chk($sformatf("vec%0d_grant", idx), grant_id, v.g);
    chk($sformatf("vec%0d_din", idx), spi_din, v.din);
    wait_ack(TO + 40, ok, n);
    chk($sformatf("vec%0d_ack_seen", idx), ok, 1);
    chk($sformatf("vec%0d_ack", idx), ack, 1 << v.g);
    chk($sformatf("vec%0d_err", idx), err, v.e ? (1 << v.g) : 0);
    chk($sformatf("vec%0d_start_low", idx), spi_start, 0);
    @(negedge clk); req = '0;
    repeat (15) @(negedge clk);
    chk($sformatf("vec%0d_ack_count", idx), ack_cnt - a0, 1);
    chk($sformatf("vec%0d_start_count", idx), start_cnt - s0, 1);
    chk($sformatf("vec%0d_idle", idx), busy, 0);
  endtask

  initial begin
    bit ok; int n, a0, s0;

    tbl[0] = '{4'b0010, 30, 1, 1'b0, 1, 12'hA5A, 1'b0};
    tbl[1] = '{4'b0001,  3, 1, 1'b0, 0, 12'h0F0, 1'b0};
    tbl[2] = '{4'b1100,  5, 2, 1'b0, 2, 12'h7E1, 1'b0};
    tbl[3] = '{4'b1000,  1, 1, 1'b0, 3, 12'hD3C, 1'b0};
    tbl[4] = '{4'b1010,  2, 5, 1'b0, 1, 12'hA5A, 1'b0};
    tbl[5] = '{4'b0100,  1, 1, 1'b1, 2, 12'h7E1, 1'b1};
    tbl[6] = '{4'b1111,  4, 1, 1'b0, 0, 12'h0F0, 1'b0};

    // reset state, asserted away from any clock edge
    #2 rst_n = 0;
    #1;
    chk("rst_start", spi_start, 0);
    chk("rst_din", spi_din, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    @(negedge clk); rst_n = 1;

    for (int i = 0; i < 7; i++) run_vec(i, tbl[i]);

    // all four request from reset, each drops on its ack
    do_reset();
    sp_delay = 3; sp_len = 1; sp_never = 0;
    grant_log.delete(); s0 = start_cnt;
    @(negedge clk); req = '1;
    for (int c = 0; c < 400 && req != '0; c++) begin
      @(negedge clk); req = req & ~ack;
    end
    repeat (5) @(negedge clk);
    chk("all4_drained", req, 0);
    chk("all4_grants", grant_log.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("all4_order%0d", i), (i < grant_log.size()) ? grant_log[i] : -1, i);
    chk("all4_starts", start_cnt - s0, 4);

    // req[0] re-requests right after each ack, req[2] held
    do_reset();
    grant_log.delete();
    @(negedge clk); req = 4'b0101;
    for (int c = 0; c < 600 && grant_log.size() < 4; c++) begin
      @(negedge clk);
      req[0] = !ack[0]; req[2] = 1'b1;
    end
    @(negedge clk); req = '0;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk($sformatf("alt_order%0d", i), (i < grant_log.size()) ? grant_log[i] : -1, (i % 2) * 2);

    // timeout latency, err pulse and pointer advance
    do_reset();
    sp_never = 1;
    @(negedge clk); req = 4'b0100;
    wait_start(10, ok, n);
    chk("to_start", ok, 1);
    wait_ack(TO + 20, ok, n);
    chk("to_latency", n, TO + 1);
    chk("to_ack", ack, 4'b0100);
    chk("to_err", err, 4'b0100);
    chk("to_start_low", spi_start, 0);
    @(negedge clk); req = '1; sp_never = 0; sp_delay = 2;
    wait_start(20, ok, n);
    chk("to_next_grant", grant_id, 3);
    wait_ack(TO + 20, ok, n);
    @(negedge clk); req = '0;
    repeat (10) @(negedge clk);

    // reset during WAIT abandons the transfer and resets the pointer
    do_reset();
    sp_never = 0; sp_delay = 2; sp_len = 1;
    @(negedge clk); req = 4'b0010;
    wait_ack(40, ok, n);
    @(negedge clk); req = '0;
    repeat (5) @(negedge clk);
    sp_never = 1; req = 4'b0100;
    wait_start(10, ok, n);
    repeat (5) @(posedge clk);
    a0 = ack_cnt;
    @(negedge clk); #2 rst_n = 0; #1;
    chk("rstw_start", spi_start, 0);
    chk("rstw_ack", ack, 0);
    chk("rstw_busy", busy, 0);
    req = 4'b1010;
    @(negedge clk); @(negedge clk); rst_n = 1; sp_never = 0;
    wait_start(10, ok, n);
    chk("rstw_regrant", grant_id, 1);
    chk("rstw_no_ack", ack_cnt - a0, 0);
    wait_ack(40, ok, n);
    @(negedge clk); req = '0;
    repeat (10) @(negedge clk);

    // level done held 5 cycles with the request kept high
    do_reset();
    sp_delay = 3; sp_len = 5; sp_never = 0;
    a0 = ack_cnt;
    @(negedge clk); req = 4'b0001;
    wait_start(10, ok, n);
    wait_ack(40, ok, n);
    chk("lvl_ack", ack, 4'b0001);
    wait_start(30, ok, n);
    chk("lvl_relaunch", ok, 1);
    chk("lvl_gap", n, 6);
    chk("lvl_done_low", spi_done, 0);
    chk("lvl_cs_high", spi_cs, 1);
    chk("lvl_one_ack", ack_cnt - a0, 1);
    wait_ack(40, ok, n);
    @(negedge clk); req = '0;
    repeat (15) @(negedge clk);

    // randomized traffic against the transaction model
    do_reset();
    m_ptr = 0; m_act = 0; rnd_txn = 0;
    sp_rand = 1; rnd_on = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (ack[k]) req[k] = ($urandom_range(3) == 0);
        else if (!req[k] && $urandom_range(3) == 0) req[k] = 1'b1;
        else if (req[k] && $urandom_range(40) == 0) req[k] = 1'b0;
        req_data[k*DW +: DW] = DW'($urandom);
      end
    end
    req = '0;
    for (int c = 0; c < 200 && busy; c++) @(negedge clk);
    chk("rnd_drained", busy, 0);
    chk("rnd_enough_txns", rnd_txn > 20, 1);
    rnd_on = 0; sp_rand = 0;

    chk("onehot_invariants", inv_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
